// File: rtl/cpu_pkg.sv
// cpu_pkg: shared definitions for the decode stage.
//   - instruction width and field bit positions
//   - opcode constants
//   - decode-stage FSM state type
//   - decoded-entry record stored in the skid FIFO
package cpu_pkg;

    localparam int INSTR_W = 16;

    // Instruction field bit positions
    localparam int OPC_HI = 15;
    localparam int OPC_LO = 12;
    localparam int RD_HI  = 11;
    localparam int RD_LO  = 8;
    localparam int RS_HI  = 7;
    localparam int RS_LO  = 4;
    localparam int RT_HI  = 3;
    localparam int RT_LO  = 0;

    // Opcodes
    localparam logic [3:0] OP_ADD    = 4'h0;
    localparam logic [3:0] OP_PADDSB = 4'h1;
    localparam logic [3:0] OP_SUB    = 4'h2;
    localparam logic [3:0] OP_XOR    = 4'h3;
    localparam logic [3:0] OP_SLL    = 4'h4;
    localparam logic [3:0] OP_SRA    = 4'h5;
    localparam logic [3:0] OP_ROR    = 4'h6;
    localparam logic [3:0] OP_RED    = 4'h7;
    localparam logic [3:0] OP_LW     = 4'h8;
    localparam logic [3:0] OP_SW     = 4'h9;
    localparam logic [3:0] OP_LLB    = 4'hA;
    localparam logic [3:0] OP_LHB    = 4'hB;
    localparam logic [3:0] OP_B      = 4'hC;
    localparam logic [3:0] OP_BR     = 4'hD;
    localparam logic [3:0] OP_PCS    = 4'hE;
    localparam logic [3:0] OP_HLT    = 4'hF;

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_HALTED = 2'd2
    } state_e;

    typedef struct packed {
        logic [3:0] opcode;
        logic [3:0] rd;
        logic [3:0] rs;
        logic [3:0] rt;
        logic [3:0] shift_val;
        logic       is_shift;
        logic       we;
    } decoded_t;

endpackage

// File: rtl/instr_decoder.sv
// instr_decoder: purely combinational field extraction for one instruction.
// Ports:
//   instr  in   16-bit instruction word
//   dec    out  decoded fields (opcode, rd, rs, rt, shift_val, is_shift, we)
module instr_decoder
    import cpu_pkg::*;
(
    input  logic [INSTR_W-1:0] instr,
    output decoded_t           dec
);

    logic [3:0] opc;

    always_comb begin
        opc           = instr[OPC_HI:OPC_LO];
        dec           = '0;
        dec.opcode    = opc;
        dec.rd        = instr[RD_HI:RD_LO];
        dec.rt        = instr[RT_HI:RT_LO];
        // LLB/LHB modify part of rd, so rd is also the source operand.
        dec.rs        = ((opc == OP_LLB) || (opc == OP_LHB)) ? instr[RD_HI:RD_LO]
                                                             : instr[RS_HI:RS_LO];
        dec.is_shift  = (opc == OP_SLL) || (opc == OP_SRA) || (opc == OP_ROR);
        dec.shift_val = dec.is_shift ? instr[RT_HI:RT_LO] : 4'h0;
        dec.we        = !((opc == OP_SW) || (opc == OP_B) ||
                          (opc == OP_BR) || (opc == OP_HLT));
    end

endmodule

// File: rtl/id_skid_decode.sv
// id_skid_decode: instruction-decode stage with a 2-entry skid FIFO.
// Instructions are decoded on the push side and the decoded record is
// buffered; the EX stage sees the head entry. An HLT stops intake, lets the
// buffer drain, and halts the stage once the HLT itself has been consumed.
// Ports:
//   clk, rst_n                  clock, async active-low reset
//   in_valid/in_ready           fetch-side handshake
//   in_instr, in_pc             fetched instruction and its PC
//   flush                       branch redirect: drop everything held/incoming
//   out_valid/out_ready         EX-side handshake
//   out_opcode/rd/rs/rt         decoded register fields of the head entry
//   out_shift_val, out_is_shift shifter controls
//   out_we                      register-file write enable
//   out_pc                      PC of the head entry
//   halted                      stage has retired an HLT
module id_skid_decode
    import cpu_pkg::*;
#(
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_instr,
    input  logic [DATA_W-1:0] in_pc,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [3:0]        out_opcode,
    output logic [3:0]        out_rd,
    output logic [3:0]        out_rs,
    output logic [3:0]        out_rt,
    output logic [3:0]        out_shift_val,
    output logic              out_is_shift,
    output logic              out_we,
    output logic [DATA_W-1:0] out_pc,
    output logic              halted
);

    state_e            state_q, state_d;
    logic [1:0]        count_q, count_d;
    decoded_t          dec_q [2];
    decoded_t          dec_d [2];
    logic [DATA_W-1:0] pc_q  [2];
    logic [DATA_W-1:0] pc_d  [2];

    decoded_t dec_in;
    logic     push;
    logic     pop;
    logic     flush_eff;

    instr_decoder u_instr_decoder (
        .instr (in_instr),
        .dec   (dec_in)
    );

    // Handshakes depend on registered state only.
    assign in_ready  = (state_q == ST_RUN) && (count_q < 2'd2);
    assign out_valid = (count_q != 2'd0) && (state_q != ST_HALTED);
    assign push      = in_valid && in_ready && !flush;
    assign pop       = out_valid && out_ready && !flush;
    // A halted stage ignores flush entirely.
    assign flush_eff = flush && (state_q != ST_HALTED);

    // FSM next state
    always_comb begin
        state_d = state_q;
        if (flush_eff) begin
            state_d = ST_RUN;
        end else begin
            case (state_q)
                ST_RUN:    if (push && (dec_in.opcode == OP_HLT)) state_d = ST_DRAIN;
                ST_DRAIN:  if (pop && (dec_q[0].opcode == OP_HLT)) state_d = ST_HALTED;
                ST_HALTED: state_d = ST_HALTED;
                default:   state_d = ST_RUN;
            endcase
        end
    end

    // FIFO next state. Slot 0 is always the head; slot 1 is the skid slot.
    always_comb begin
        count_d = count_q;
        dec_d   = dec_q;
        pc_d    = pc_q;
        if (flush_eff) begin
            count_d = 2'd0;
        end else begin
            case ({push, pop})
                2'b10: begin
                    // count is 0 or 1 here, so its LSB selects the free slot
                    dec_d[count_q[0]] = dec_in;
                    pc_d[count_q[0]]  = in_pc;
                    count_d           = count_q + 2'd1;
                end
                2'b01: begin
                    // Only advance the skid slot when it holds a live entry;
                    // an emptied buffer keeps showing the last head.
                    if (count_q == 2'd2) begin
                        dec_d[0] = dec_q[1];
                        pc_d[0]  = pc_q[1];
                    end
                    count_d = count_q - 2'd1;
                end
                2'b11: begin
                    // Both can only fire at count 1: the new beat replaces the head.
                    dec_d[0] = dec_in;
                    pc_d[0]  = in_pc;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_RUN;
            count_q <= 2'd0;
            dec_q   <= '{default: '0};
            pc_q    <= '{default: '0};
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            dec_q   <= dec_d;
            pc_q    <= pc_d;
        end
    end

    assign out_opcode    = dec_q[0].opcode;
    assign out_rd        = dec_q[0].rd;
    assign out_rs        = dec_q[0].rs;
    assign out_rt        = dec_q[0].rt;
    assign out_shift_val = dec_q[0].shift_val;
    assign out_is_shift  = dec_q[0].is_shift;
    assign out_we        = dec_q[0].we;
    assign out_pc        = pc_q[0];
    assign halted        = (state_q == ST_HALTED);

endmodule

// File: tb/tb_id_skid_decode.sv
module tb_id_skid_decode;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] in_instr = '0;
    logic [15:0] in_pc = '0;
    logic        flush = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [3:0]  out_opcode, out_rd, out_rs, out_rt, out_shift_val;
    logic        out_is_shift, out_we;
    logic [15:0] out_pc;
    logic        halted;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    id_skid_decode #(.DATA_W(16)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_instr      (in_instr),
        .in_pc         (in_pc),
        .flush         (flush),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_opcode    (out_opcode),
        .out_rd        (out_rd),
        .out_rs        (out_rs),
        .out_rt        (out_rt),
        .out_shift_val (out_shift_val),
        .out_is_shift  (out_is_shift),
        .out_we        (out_we),
        .out_pc        (out_pc),
        .halted        (halted)
    );

    typedef struct {
        logic [15:0] instr;
        logic [15:0] pc;
        logic [3:0]  op;
        logic [3:0]  rd;
        logic [3:0]  rs;
        logic [3:0]  rt;
        logic [3:0]  sv;
        logic        is_shift;
        logic        we;
    } vec_t;

    vec_t vecs [15];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [15:0] instr, input logic [15:0] pc);
        in_valid = 1'b1;
        in_instr = instr;
        in_pc    = pc;
    endtask

    initial begin
        //             instr     pc        op    rd    rs    rt    sv    sh    we
        vecs[0]  = '{16'h4A3C, 16'h0010, 4'h4, 4'hA, 4'h3, 4'hC, 4'hC, 1'b1, 1'b1};
        vecs[1]  = '{16'h0123, 16'h0012, 4'h0, 4'h1, 4'h2, 4'h3, 4'h0, 1'b0, 1'b1};
        vecs[2]  = '{16'h1456, 16'h0014, 4'h1, 4'h4, 4'h5, 4'h6, 4'h0, 1'b0, 1'b1};
        vecs[3]  = '{16'h2789, 16'h0016, 4'h2, 4'h7, 4'h8, 4'h9, 4'h0, 1'b0, 1'b1};
        vecs[4]  = '{16'h3ABC, 16'h0018, 4'h3, 4'hA, 4'hB, 4'hC, 4'h0, 1'b0, 1'b1};
        vecs[5]  = '{16'h5DEF, 16'h001A, 4'h5, 4'hD, 4'hE, 4'hF, 4'hF, 1'b1, 1'b1};
        vecs[6]  = '{16'h6125, 16'h001C, 4'h6, 4'h1, 4'h2, 4'h5, 4'h5, 1'b1, 1'b1};
        vecs[7]  = '{16'h7321, 16'h001E, 4'h7, 4'h3, 4'h2, 4'h1, 4'h0, 1'b0, 1'b1};
        vecs[8]  = '{16'h8654, 16'h0020, 4'h8, 4'h6, 4'h5, 4'h4, 4'h0, 1'b0, 1'b1};
        vecs[9]  = '{16'h9123, 16'h0022, 4'h9, 4'h1, 4'h2, 4'h3, 4'h0, 1'b0, 1'b0};
        vecs[10] = '{16'hB456, 16'h0024, 4'hB, 4'h4, 4'h4, 4'h6, 4'h0, 1'b0, 1'b1};
        vecs[11] = '{16'hA7C5, 16'h0026, 4'hA, 4'h7, 4'h7, 4'h5, 4'h0, 1'b0, 1'b1};
        vecs[12] = '{16'hC321, 16'h0028, 4'hC, 4'h3, 4'h2, 4'h1, 4'h0, 1'b0, 1'b0};
        vecs[13] = '{16'hD0F0, 16'h002A, 4'hD, 4'h0, 4'hF, 4'h0, 4'h0, 1'b0, 1'b0};
        vecs[14] = '{16'hE500, 16'h002C, 4'hE, 4'h5, 4'h0, 4'h0, 4'h0, 1'b0, 1'b1};

        // ---- reset state
        repeat (2) @(negedge clk);
        chk("rst_in_ready",  in_ready,   1);
        chk("rst_out_valid", out_valid,  0);
        chk("rst_halted",    halted,     0);
        chk("rst_out_pc",    out_pc,     0);
        chk("rst_out_op",    out_opcode, 0);
        $display("txn reset: in_ready=%0b out_valid=%0b halted=%0b", in_ready, out_valid, halted);
        rst_n = 1'b1;

        // ---- decode table, one instruction at a time, EX always ready
        out_ready = 1'b1;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            drive(vecs[i].instr, vecs[i].pc);
            @(negedge clk);
            in_valid = 1'b0;
            chk($sformatf("v%0d_valid", i), out_valid, 1);
            chk($sformatf("v%0d_op", i), out_opcode, vecs[i].op);
            chk($sformatf("v%0d_rd", i), out_rd, vecs[i].rd);
            chk($sformatf("v%0d_rs", i), out_rs, vecs[i].rs);
            chk($sformatf("v%0d_rt", i), out_rt, vecs[i].rt);
            chk($sformatf("v%0d_sv", i), out_shift_val, vecs[i].sv);
            chk($sformatf("v%0d_shift", i), out_is_shift, vecs[i].is_shift);
            chk($sformatf("v%0d_we", i), out_we, vecs[i].we);
            chk($sformatf("v%0d_pc", i), out_pc, vecs[i].pc);
            $display("txn vec %0d instr=%h pc=%h -> op=%h rd=%h rs=%h rt=%h sv=%h sh=%0b we=%0b",
                     i, vecs[i].instr, vecs[i].pc, out_opcode, out_rd, out_rs, out_rt,
                     out_shift_val, out_is_shift, out_we);
        end

        // ---- fill to 2 with EX stalled, third beat held, then drain in order
        @(negedge clk);
        chk("fill_empty", out_valid, 0);
        out_ready = 1'b0;
        drive(16'h0100, 16'h0100);
        @(negedge clk);
        drive(16'h0200, 16'h0102);
        @(negedge clk);
        chk("full_in_ready", in_ready, 0);
        chk("full_head_pc",  out_pc, 16'h0100);
        drive(16'h0300, 16'h0104);
        @(negedge clk);
        chk("full_held_in_ready", in_ready, 0);
        chk("full_held_head_pc",  out_pc, 16'h0100);
        out_ready = 1'b1;
        @(negedge clk);
        chk("drain1_pc",       out_pc, 16'h0102);
        chk("drain1_in_ready", in_ready, 1);
        @(negedge clk);
        in_valid = 1'b0;
        chk("drain2_pc",    out_pc, 16'h0104);
        chk("drain2_valid", out_valid, 1);
        @(negedge clk);
        chk("drain_empty", out_valid, 0);
        $display("txn fifo fill/hold/drain done");

        // ---- flush at count 2 with a simultaneous incoming beat
        out_ready = 1'b0;
        drive(16'h0111, 16'h0300);
        @(negedge clk);
        drive(16'h0222, 16'h0302);
        @(negedge clk);
        chk("fl_full_in_ready", in_ready, 0);
        drive(16'h0444, 16'h0304);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        in_valid = 1'b0;
        chk("fl_out_valid", out_valid, 0);
        chk("fl_in_ready",  in_ready, 1);
        @(negedge clk);
        chk("fl_no_retain", out_valid, 0);
        drive(16'h0555, 16'h0306);
        @(negedge clk);
        in_valid = 1'b0;
        chk("fl_after_valid", out_valid, 1);
        chk("fl_after_pc",    out_pc, 16'h0306);
        chk("fl_after_rd",    out_rd, 4'h5);
        out_ready = 1'b1;
        @(negedge clk);
        chk("fl_after_empty", out_valid, 0);
        $display("txn flush at full done");

        // ---- flush while draining returns to RUN
        out_ready = 1'b0;
        drive(16'hF000, 16'h0310);
        @(negedge clk);
        in_valid = 1'b0;
        chk("fd_drain_in_ready", in_ready, 0);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        chk("fd_in_ready",  in_ready, 1);
        chk("fd_out_valid", out_valid, 0);
        chk("fd_halted",    halted, 0);
        $display("txn flush in drain done");

        // ---- HLT behind an ADD
        drive(16'h0123, 16'h0200);
        @(negedge clk);
        drive(16'hF000, 16'h0202);
        @(negedge clk);
        in_valid = 1'b0;
        chk("hlt_in_ready", in_ready, 0);
        chk("hlt_head_pc",  out_pc, 16'h0200);
        chk("hlt_halted0",  halted, 0);
        out_ready = 1'b1;
        @(negedge clk);
        chk("hlt_head_op", out_opcode, 4'hF);
        chk("hlt_head_pc2", out_pc, 16'h0202);
        chk("hlt_we",      out_we, 0);
        chk("hlt_valid",   out_valid, 1);
        chk("hlt_halted1", halted, 0);
        @(negedge clk);
        chk("hlt_halted",      halted, 1);
        chk("hlt_out_valid",   out_valid, 0);
        chk("hlt_in_ready_h",  in_ready, 0);
        drive(16'h0123, 16'h0400);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        chk("hlt_stay_halted", halted, 1);
        chk("hlt_stay_ov",     out_valid, 0);
        chk("hlt_stay_ir",     in_ready, 0);
        $display("txn halt sequence done");

        // ---- async reset with count 2 in DRAIN
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b0;
        drive(16'h0123, 16'h0500);
        @(negedge clk);
        drive(16'hF000, 16'h0502);
        @(negedge clk);
        in_valid = 1'b0;
        chk("ar_pre_in_ready", in_ready, 0);
        chk("ar_pre_valid",    out_valid, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar_out_valid", out_valid, 0);
        chk("ar_in_ready",  in_ready, 1);
        chk("ar_halted",    halted, 0);
        chk("ar_out_pc",    out_pc, 0);
        chk("ar_out_op",    out_opcode, 0);
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        drive(16'h0ABC, 16'h0600);
        @(negedge clk);
        in_valid = 1'b0;
        chk("ar_post_valid", out_valid, 1);
        chk("ar_post_pc",    out_pc, 16'h0600);
        chk("ar_post_rd",    out_rd, 4'hA);
        $display("txn async reset done");

        @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
